regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_pkg.sv | 9 +
 rtl/regfile_sb_readport.sv | 37 +++
 rtl/regfile_sb.sv | 88 ++++++++
 tb/tb_regfile_sb.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared defaults for the scoreboarded register file: geometry and stack-pointer reset value.
package regfile_sb_pkg;

    localparam int          RF_WIDTH    = 32;
    localparam int          RF_DEPTH    = 32;
    localparam int          RF_SP_INDEX = 29;
    localparam logic [31:0] RF_SP_INIT  = 32'h0000_3FFC;

endpackage

// File: rtl/regfile_sb_readport.sv
// One asynchronous read port: register mux, write-through bypass and busy lookup.
module regfile_sb_readport #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_regs [DEPTH],
    input  logic [DEPTH-1:0] i_busy,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_busy
);

    logic w_valid;
    logic w_bypass;

    // r0 and addresses past the end of a non-power-of-2 file behave as constant zero
    assign w_valid  = (i_addr != '0) && (int'(i_addr) < DEPTH);
    assign w_bypass = w_valid && i_wr_en && (i_wr_addr == i_addr);

    always_comb begin
        o_data = '0;
        o_busy = 1'b0;
        if (w_bypass) begin
            o_data = i_wr_data;
        end else if (w_valid) begin
            o_data = i_regs[i_addr];
        end
        if (w_valid) begin
            o_busy = i_busy[i_addr] && !w_bypass;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register busy bits (scoreboard) and combinational issue stall.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int               WIDTH    = RF_WIDTH,
    parameter int               DEPTH    = RF_DEPTH,
    parameter int               NREAD    = 2,
    parameter int               SP_INDEX = RF_SP_INDEX,
    parameter logic [WIDTH-1:0] SP_INIT  = WIDTH'(RF_SP_INIT)
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic [NREAD*$clog2(DEPTH)-1:0] ReadRegister,
    input  logic [NREAD-1:0]               ReadUse,
    output logic [NREAD*WIDTH-1:0]         ReadData,
    output logic [NREAD-1:0]               ReadBusy,
    input  logic [$clog2(DEPTH)-1:0]       WriteRegister,
    input  logic [WIDTH-1:0]               WriteData,
    input  logic                           RegWrite,
    input  logic [$clog2(DEPTH)-1:0]       ReserveRegister,
    input  logic                           Reserve,
    output logic                           Stall
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;

    logic             w_wr_hit;
    logic             w_rsv_hit;
    logic             w_rsv_busy;
    logic             w_waw;
    logic             w_stall;
    logic [NREAD-1:0] w_read_busy;

    assign w_wr_hit   = RegWrite && (WriteRegister != '0) && (int'(WriteRegister) < DEPTH);
    assign w_rsv_hit  = Reserve && (ReserveRegister != '0) && (int'(ReserveRegister) < DEPTH);
    assign w_rsv_busy = w_rsv_hit && r_busy[ReserveRegister];
    // A writeback retiring the same destination this cycle frees it for re-reservation
    assign w_waw      = w_rsv_busy && !(w_wr_hit && (WriteRegister == ReserveRegister));
    assign w_stall    = (|(ReadUse & w_read_busy)) || w_waw;

    assign ReadBusy = w_read_busy;
    assign Stall    = w_stall;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= (i == SP_INDEX) ? SP_INIT : '0;
            end
        end else if (w_wr_hit) begin
            r_regs[WriteRegister] <= WriteData;
        end
    end

    // The set is scheduled after the clear so a same-edge reserve of the written register wins
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_busy <= '0;
        end else begin
            if (w_wr_hit) begin
                r_busy[WriteRegister] <= 1'b0;
            end
            if (w_rsv_hit && !w_stall) begin
                r_busy[ReserveRegister] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rport
        regfile_sb_readport #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_rport (
            .i_addr    (ReadRegister[k*AW +: AW]),
            .i_regs    (r_regs),
            .i_busy    (r_busy),
            .i_wr_en   (RegWrite),
            .i_wr_addr (WriteRegister),
            .i_wr_data (WriteData),
            .o_data    (ReadData[k*WIDTH +: WIDTH]),
            .o_busy    (w_read_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, bypass, scoreboard hazards, WAW guard and async reset.
module tb_regfile_sb;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          Clk;
    logic          Reset_n;
    logic [2*AW-1:0] ReadRegister;
    logic [1:0]    ReadUse;
    logic [2*W-1:0] ReadData;
    logic [1:0]    ReadBusy;
    logic [AW-1:0] WriteRegister;
    logic [W-1:0]  WriteData;
    logic          RegWrite;
    logic [AW-1:0] ReserveRegister;
    logic          Reserve;
    logic          Stall;

    int n_tests;
    int n_fail;

    regfile_sb dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .ReadRegister    (ReadRegister),
        .ReadUse         (ReadUse),
        .ReadData        (ReadData),
        .ReadBusy        (ReadBusy),
        .WriteRegister   (WriteRegister),
        .WriteData       (WriteData),
        .RegWrite        (RegWrite),
        .ReserveRegister (ReserveRegister),
        .Reserve         (Reserve),
        .Stall           (Stall)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ReadRegister = {a1, a0};
    endtask

    function automatic logic [31:0] rd0();
        return ReadData[W-1:0];
    endfunction

    function automatic logic [31:0] rd1();
        return ReadData[2*W-1:W];
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        Reset_n = 1'b0;
        ReadRegister = '0;
        ReadUse = 2'b00;
        WriteRegister = '0;
        WriteData = '0;
        RegWrite = 1'b0;
        ReserveRegister = '0;
        Reserve = 1'b0;

        // Reset state
        #12;
        set_rd(5'd0, 5'd5);
        #1;
        check("rst_r0", rd0(), 32'h0);
        check("rst_r5", rd1(), 32'h0);
        set_rd(5'd29, 5'd5);
        #1;
        check("rst_r29", rd0(), 32'h0000_3FFC);
        @(negedge Clk);
        Reset_n = 1'b1;
        ReadUse = 2'b11;
        #1;
        check("rel_busy", {30'd0, ReadBusy}, 32'h0);
        check("rel_stall", {31'd0, Stall}, 32'h0);

        // Write-through bypass on the first edge after release
        ReadUse = 2'b00;
        set_rd(5'd7, 5'd0);
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'hDEAD_BEEF;
        #1;
        check("byp_r7", rd0(), 32'hDEAD_BEEF);
        tick();
        RegWrite = 1'b0; WriteData = '0;
        #1;
        check("held_r7", rd0(), 32'hDEAD_BEEF);

        // RAW hazard resolved by writeback bypass
        Reserve = 1'b1; ReserveRegister = 5'd3;
        tick();
        Reserve = 1'b0;
        set_rd(5'd0, 5'd3);
        ReadUse = 2'b10;
        #1;
        check("raw_busy", {31'd0, ReadBusy[1]}, 32'h1);
        check("raw_stall", {31'd0, Stall}, 32'h1);
        tick();
        RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'h12;
        #1;
        check("wb_stall", {31'd0, Stall}, 32'h0);
        check("wb_busy", {31'd0, ReadBusy[1]}, 32'h0);
        check("wb_byp", rd1(), 32'h12);
        tick();
        RegWrite = 1'b0; ReadUse = 2'b00;
        #1;
        check("r3_data", rd1(), 32'h12);
        check("r3_free", {31'd0, ReadBusy[1]}, 32'h0);

        // Same-edge reserve and writeback: data lands, busy set wins
        Reserve = 1'b1; ReserveRegister = 5'd4;
        RegWrite = 1'b1; WriteRegister = 5'd4; WriteData = 32'h0000_ABCD;
        tick();
        Reserve = 1'b0; RegWrite = 1'b0;
        set_rd(5'd4, 5'd0);
        #1;
        check("r4_data", rd0(), 32'h0000_ABCD);
        check("r4_busy", {31'd0, ReadBusy[0]}, 32'h1);

        // Reserve while stalled has no effect
        ReadUse = 2'b01;
        Reserve = 1'b1; ReserveRegister = 5'd10;
        #1;
        check("stall_r4", {31'd0, Stall}, 32'h1);
        tick();
        Reserve = 1'b0; ReadUse = 2'b00;
        set_rd(5'd4, 5'd10);
        #1;
        check("r10_free", {31'd0, ReadBusy[1]}, 32'h0);

        // WAW guard on double reservation
        Reserve = 1'b1; ReserveRegister = 5'd9;
        #1;
        check("r9_first", {31'd0, Stall}, 32'h0);
        tick();
        #1;
        check("waw_stall", {31'd0, Stall}, 32'h1);
        tick();
        Reserve = 1'b0;
        set_rd(5'd4, 5'd9);
        #1;
        check("r9_busy", {31'd0, ReadBusy[1]}, 32'h1);

        // r0 is hardwired zero: write and reservation ignored
        set_rd(5'd0, 5'd0);
        RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'hFFFF_FFFF;
        Reserve = 1'b1; ReserveRegister = 5'd0;
        ReadUse = 2'b11;
        #1;
        check("r0_nobyp", rd0(), 32'h0);
        tick();
        RegWrite = 1'b0; Reserve = 1'b0;
        #1;
        check("r0_zero", rd0(), 32'h0);
        check("r0_busy", {30'd0, ReadBusy}, 32'h0);
        check("r0_stall", {31'd0, Stall}, 32'h0);
        ReadUse = 2'b00;

        // Asynchronous reset mid-cycle discards reservations and restores SP
        RegWrite = 1'b1; WriteRegister = 5'd29; WriteData = 32'h0000_1000;
        tick();
        WriteRegister = 5'd2; WriteData = 32'h0000_0055;
        Reserve = 1'b1; ReserveRegister = 5'd2;
        tick();
        RegWrite = 1'b0; Reserve = 1'b0;
        set_rd(5'd2, 5'd29);
        #1;
        check("r2_data", rd0(), 32'h0000_0055);
        check("r2_busy", {31'd0, ReadBusy[0]}, 32'h1);
        check("r29_data", rd1(), 32'h0000_1000);
        #1;
        Reset_n = 1'b0;
        #1;
        check("arst_r2", rd0(), 32'h0);
        check("arst_busy", {30'd0, ReadBusy}, 32'h0);
        check("arst_r29", rd1(), 32'h0000_3FFC);
        @(negedge Clk);
        Reset_n = 1'b1;
        set_rd(5'd2, 5'd4);
        ReadUse = 2'b11;
        Reserve = 1'b1; ReserveRegister = 5'd9;
        #1;
        check("post_stall", {31'd0, Stall}, 32'h0);
        check("post_busy", {30'd0, ReadBusy}, 32'h0);
        Reserve = 1'b0; ReadUse = 2'b00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
